branch_trace_buffer: RTL and testbench
======================================

# branch_trace_buffer

Captures a record of every taken branch reported on the CPU debug bus. On each rising edge of `debug_change_pc` it stores the PC, data address and data value in a first-word-fall-through FIFO. A consumer, such as a UART dumper or a bench checker, drains the FIFO through a valid/ready read port. The block sits beside `CPU`, taps its debug outputs passively and never drives the CPU.

## Interface
Parameters:
- `DEPTH`, default 16: number of trace entries. Must be a power of two, 2..256.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width. Derived; not overridden.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: capture is armed while high.
- `clear` in 1: synchronous flush of the FIFO and all status.
- `debug_pc` in 16: CPU PC.
- `debug_state` in 2: CPU FSM state. Stored in the entry.
- `debug_change_pc` in 1: branch-taken strobe from the CPU.
- `debug_data_address` in 16: address presented with the branch.
- `debug_data_value` in 32: data presented with the branch.
- `rd_valid` out 1: head entry is available.
- `rd_ready` in 1: consumer accepts the head entry.
- `rd_data` out 66: head entry, packed as {state[65:64], pc[63:48], addr[47:32], data[31:0]}.
- `count` out `ADDR_W+1`: number of entries held, 0..DEPTH.
- `overflow` out 1: sticky; set when any capture was dropped.
- `drop_count` out 8: number of dropped captures, saturating at 255.
- `rd_timestamp` out 16: present only with `TRACE_TIMESTAMP_EN` (see Configuration).

## Operation
- Edge detect:
  - `chg_q` registers `debug_change_pc` every cycle.
  - `capture = enable & debug_change_pc & ~chg_q`.
  - A strobe held high for several cycles gives one capture.
  - `chg_q` updates even while `enable` is low, so arming mid-pulse does not produce a capture.
- Push: when `capture` is true and the FIFO is not full, write the entry sampled at the same clock edge to `mem[wr_ptr]`, then `wr_ptr += 1`.
- Pop: `rd_valid & rd_ready`, then `rd_ptr += 1`.
- Pointers wrap modulo DEPTH. Full and empty are decided from `count`, not from pointer comparison.
- Simultaneous push and pop:
  - Not full: both occur and `count` is unchanged.
  - Full: the pop frees a slot, the push is accepted and `count` stays DEPTH. No drop.
- Drop: `capture` while full with no pop in the same cycle. Entry discarded, `overflow` set to 1, `drop_count` incremented (stays at 255 once reached).
- `rd_ready` while `rd_valid` is 0 has no effect.
- `clear`:
  - Pointers, `count`, `overflow` and `drop_count` go to 0.
  - Has priority over a push and a pop in the same cycle.
  - `chg_q` still updates.
- `reset`: same effect as `clear`, plus `chg_q` goes to 0. Memory contents are not reset.

## Timing
- Reset values:
  - `rd_valid` 0, `count` 0, `overflow` 0, `drop_count` 0.
  - `rd_data` don't-care while `rd_valid` is 0. Bench must not check it.
  - `rd_timestamp` 0 when built.
- Capture latency: strobe first seen high at edge N, entry written at edge N, so `rd_valid` is 1 and `rd_data` is valid from just after edge N.
- Output sources:
  - `rd_valid` is `count != 0`, driven from registers.
  - `rd_data` is a combinational read of `mem[rd_ptr]`.
  - No combinational path from `rd_ready` to `rd_valid` or `rd_data`.
- Back-to-back:
  - One capture per cycle maximum. Strobes 0→1 on alternate cycles each capture.
  - One pop per cycle. Continuous `rd_ready` drains DEPTH entries in DEPTH cycles.
- Reset or clear asserted mid-stream: from the next cycle `rd_valid` is 0 and entries are lost. Up to that edge a consumer may have popped normally.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - A 16-bit free-running cycle counter runs, reset to 0 by `reset` and not by `clear`. It wraps at 65535 to 0.
  - Each entry additionally stores the counter value at the capture edge.
  - The stored value appears on the `rd_timestamp` port, aligned with `rd_data`.
- Not defined: no counter, no timestamp storage, no `rd_timestamp` port. All other behaviour is identical.

## Test plan
- Single branch: after reset, `enable`=1, `debug_pc`=0x0010, addr 0x0004, data 0xDEADBEEF, state 2, strobe high for 3 cycles → exactly one entry, `rd_data`=0x2_0010_0004_DEADBEEF, `count`=1. Pop → `count`=0, `rd_valid`=0.
- Fill and overflow: DEPTH+3 captures (19 at DEPTH=16) with `rd_ready`=0 → `count`=16, `overflow`=1, `drop_count`=3. Drain → the first 16 PCs come out in order.
- Full with simultaneous push and pop: FIFO full, capture and pop in the same cycle → `count` stays 16, `drop_count` unchanged, new entry read last.
- Wrap-around: push 10, pop 10, push 12, pop 12 with distinct PCs → exact order preserved across the pointer wrap, `count` ends at 0.
- Disable and clear: `enable`=0 with strobes → `count` stays 0. Then 5 captures with `enable`=1, then `clear` in the same cycle as a capture → `count`=0, `overflow`=0, next capture gives `count`=1.
- Timestamp (macro defined): captures at cycles 5 and 9 after reset release → `rd_timestamp` reads 5 then 9. Without the macro the build has no `rd_timestamp` port.

Source files
------------

// File: rtl/branch_trace_buffer.sv
// First-word-fall-through trace FIFO of taken branches seen on the CPU debug bus.
// Optional feature: define TRACE_TIMESTAMP_EN to store a 16-bit cycle stamp per entry.
module branch_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [15:0]       debug_pc,
  input  logic [1:0]        debug_state,
  input  logic              debug_change_pc,
  input  logic [15:0]       debug_data_address,
  input  logic [31:0]       debug_data_value,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [65:0]       rd_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        drop_count
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [15:0]       rd_timestamp
`endif
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic              r_chg_q;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [7:0]        r_drop_count;
  logic [65:0]       r_mem [DEPTH];

  logic w_capture;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_flush;

  assign w_flush   = reset | clear;
  assign w_capture = enable & debug_change_pc & ~r_chg_q;
  assign w_full    = (r_count == FULL_COUNT);
  assign w_pop     = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a capture while full is only dropped without one.
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  assign rd_valid   = (r_count != '0);
  assign rd_data    = r_mem[r_rd_ptr];
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chg_q <= 1'b0;
    end else begin
      r_chg_q <= debug_change_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (ADDR_W+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (ADDR_W+1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= {debug_state, debug_pc, debug_data_address, debug_data_value};
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] r_timestamp;
  logic [15:0] r_ts_mem [DEPTH];

  // Free-running stamp survives clear so stamps stay comparable across flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timestamp <= 16'd0;
    end else begin
      r_timestamp <= r_timestamp + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_ts_mem[r_wr_ptr] <= r_timestamp;
    end
  end

  assign rd_timestamp = rd_valid ? r_ts_mem[r_rd_ptr] : 16'd0;
`endif

endmodule

// File: tb/tb_branch_trace_buffer.sv
// Directed, table-driven bench for branch_trace_buffer at DEPTH=16.
// Define TRACE_TIMESTAMP_EN to also exercise the timestamp port.
module tb_branch_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [15:0] debug_pc;
  logic [1:0]  debug_state;
  logic        debug_change_pc;
  logic [15:0] debug_data_address;
  logic [31:0] debug_data_value;
  logic        rd_valid;
  logic        rd_ready;
  logic [65:0] rd_data;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] rd_timestamp;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        chg;
    logic        rdy;
    logic        clr;
    logic [15:0] pc;
    logic        expValid;
    int          expCount;
    logic        expOvf;
    logic        chkHead;
    logic [15:0] headPc;
  } vec_t;

  vec_t vecs[24];

  branch_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .clear              (clear),
    .debug_pc           (debug_pc),
    .debug_state        (debug_state),
    .debug_change_pc    (debug_change_pc),
    .debug_data_address (debug_data_address),
    .debug_data_value   (debug_data_value),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_data            (rd_data),
    .count              (count),
    .overflow           (overflow),
    .drop_count         (drop_count)
`ifdef TRACE_TIMESTAMP_EN
    ,
    .rd_timestamp       (rd_timestamp)
`endif
  );

  always #5 clk = ~clk;

  // Each PC maps to a unique, easily recomputed entry so one value checks every field.
  function automatic logic [65:0] entryFor(input logic [15:0] pc);
    return {pc[1:0], pc, ~pc, pc, pc ^ 16'hA5A5};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic chg, input logic rdy,
                               input logic clr, input logic [15:0] pc);
    enable             = en;
    debug_change_pc    = chg;
    rd_ready           = rdy;
    clear              = clr;
    debug_pc           = pc;
    debug_state        = pc[1:0];
    debug_data_address = ~pc;
    debug_data_value   = {pc, pc ^ 16'hA5A5};
  endtask

  task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic expValid, input int expCount,
                             input logic expOvf, input int expDrop);
    checkOutput({tag, ".rd_valid"}, 66'(rd_valid), 66'(expValid));
    checkOutput({tag, ".count"}, 66'(count), 66'(expCount));
    checkOutput({tag, ".overflow"}, 66'(overflow), 66'(expOvf));
    checkOutput({tag, ".drop_count"}, 66'(drop_count), 66'(expDrop));
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic doClear();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic pushOne(input logic [15:0] pc);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, pc);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, pc);
    stepCycle();
  endtask

  task automatic popExpect(input string name, input logic [15:0] pc);
    checkOutput(name, rd_data, entryFor(pc));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    stepCycle();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b1, 1, 1'b0, 1'b1, 16'h0100};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b1, 1, 1'b0, 1'b1, 16'h0100};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0101, 1'b1, 2, 1'b0, 1'b1, 16'h0100};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b1, 2, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0102, 1'b1, 3, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0102, 1'b1, 3, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0103, 1'b1, 4, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0103, 1'b1, 4, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0104, 1'b1, 5, 1'b0, 1'b1, 16'h0100};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0104, 1'b1, 5, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0105, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0105, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0106, 1'b1, 1, 1'b0, 1'b1, 16'h0106};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0106, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0106, 1'b0, 0, 1'b0, 1'b0, 16'h0000};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0107, 1'b1, 1, 1'b0, 1'b1, 16'h0107};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0107, 1'b1, 1, 1'b0, 1'b1, 16'h0107};
    vecs[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0108, 1'b1, 1, 1'b0, 1'b1, 16'h0108};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0108, 1'b0, 0, 1'b0, 1'b0, 16'h0000};

    @(negedge clk);
    doReset();
    checkStatus("reset", 1'b0, 0, 1'b0, 0);

    // Single branch with a strobe held for three cycles.
    enable             = 1'b1;
    debug_pc           = 16'h0010;
    debug_data_address = 16'h0004;
    debug_data_value   = 32'hDEADBEEF;
    debug_state        = 2'd2;
    debug_change_pc    = 1'b1;
    stepCycle();
    checkOutput("single.rd_data", rd_data, 66'h2_0010_0004_DEADBEEF);
    checkStatus("single.first", 1'b1, 1, 1'b0, 0);
    stepCycle();
    stepCycle();
    checkStatus("single.held", 1'b1, 1, 1'b0, 0);
    debug_change_pc = 1'b0;
    rd_ready        = 1'b1;
    stepCycle();
    checkStatus("single.pop", 1'b0, 0, 1'b0, 0);

    // Enable gating, edge detect, clear priority, simultaneous push/pop.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].en, vecs[i].chg, vecs[i].rdy, vecs[i].clr, vecs[i].pc);
      stepCycle();
      checkStatus($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expCount, vecs[i].expOvf, 0);
      if (vecs[i].chkHead) begin
        checkOutput($sformatf("vec%0d.head", i), rd_data, entryFor(vecs[i].headPc));
      end
    end

    // Fill past capacity, then drain in order at one pop per cycle.
    doClear();
    for (int i = 0; i < DEPTH + 3; i++) begin
      pushOne(16'h0200 + 16'(i));
    end
    checkStatus("overflow.full", 1'b1, DEPTH, 1'b1, 3);
    for (int i = 0; i < DEPTH; i++) begin
      popExpect($sformatf("overflow.drain%0d", i), 16'h0200 + 16'(i));
    end
    checkStatus("overflow.empty", 1'b0, 0, 1'b1, 3);

    // Full with a capture and a pop in the same cycle.
    doClear();
    checkStatus("fullpp.clear", 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      pushOne(16'h0300 + 16'(i));
    end
    checkStatus("fullpp.full", 1'b1, DEPTH, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h03FF);
    stepCycle();
    checkStatus("fullpp.both", 1'b1, DEPTH, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      popExpect($sformatf("fullpp.drain%0d", i), (i < DEPTH - 1) ? 16'h0301 + 16'(i) : 16'h03FF);
    end
    checkStatus("fullpp.empty", 1'b0, 0, 1'b0, 0);

    // Pointer wrap-around.
    doClear();
    for (int i = 0; i < 10; i++) pushOne(16'h0400 + 16'(i));
    for (int i = 0; i < 10; i++) popExpect($sformatf("wrap.a%0d", i), 16'h0400 + 16'(i));
    for (int i = 0; i < 12; i++) pushOne(16'h0500 + 16'(i));
    checkStatus("wrap.twelve", 1'b1, 12, 1'b0, 0);
    for (int i = 0; i < 12; i++) popExpect($sformatf("wrap.b%0d", i), 16'h0500 + 16'(i));
    checkStatus("wrap.end", 1'b0, 0, 1'b0, 0);

    // Reset in the middle of a stream, then a fresh capture.
    for (int i = 0; i < 3; i++) pushOne(16'h0600 + 16'(i));
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    stepCycle();
    reset = 1'b0;
    checkStatus("midreset", 1'b0, 0, 1'b0, 0);
    pushOne(16'h0700);
    checkStatus("midreset.after", 1'b1, 1, 1'b0, 0);
    checkOutput("midreset.head", rd_data, entryFor(16'h0700));

`ifdef TRACE_TIMESTAMP_EN
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    stepCycle();
    reset = 1'b0;
    checkOutput("ts.reset", 66'(rd_timestamp), 66'd0);
    // Edge k after release sees the stamp value k.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, (k == 5 || k == 9), 1'b0, 1'b0, 16'h0800 + 16'(k));
      stepCycle();
    end
    checkOutput("ts.first", 66'(rd_timestamp), 66'd5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    stepCycle();
    checkOutput("ts.second", 66'(rd_timestamp), 66'd9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
